// File: rtl/ctrl_pkg.sv
// Shared encodings for the datapath sequencer: FSM states, ALU/shift codes and mux selects.
package ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOADA = 3'd1;
    localparam logic [2:0] ST_LOADB = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_LSL  = 2'b01;
    localparam logic [1:0] SHIFT_LSR  = 2'b10;
    localparam logic [1:0] SHIFT_ASR  = 2'b11;

    localparam logic ASEL_REG  = 1'b0;
    localparam logic ASEL_ZERO = 1'b1;
    localparam logic BSEL_REG  = 1'b0;
    localparam logic VSEL_C    = 1'b1;

    // NOT B is the only op whose result does not depend on A.
    function automatic logic ignores_a(input logic [1:0] op);
        return op == ALU_NOTB;
    endfunction

endpackage

// File: rtl/ctrl_op_counter.sv
// Wrapping count of completed commands; increments on each done pulse.
module ctrl_op_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multicycle sequencer stepping the regfile/shifter/ALU datapath for one command at a time.
// Optional CTRL_SKIP_A_EN: NOT B commands skip the A-register load and force A to zero.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rn,
    input  logic [REG_ADDR_W-1:0] cmd_rm,
    input  logic [REG_ADDR_W-1:0] cmd_rd,
    input  logic [1:0]            cmd_shift,
    input  logic                  cmd_wb,
    output logic [REG_ADDR_W-1:0] readnum,
    output logic [REG_ADDR_W-1:0] writenum,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic                  vsel,
    output logic [1:0]            shift,
    output logic [1:0]            ALUop,
    output logic                  done,
    output logic [CNT_W-1:0]      op_count
);

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, shift_q;
    logic [REG_ADDR_W-1:0] rn_q, rm_q, rd_q;
    logic                  wb_q;
    logic                  accept;
    logic                  skip_new, skip_cur;

`ifdef CTRL_SKIP_A_EN
    assign skip_new = ignores_a(cmd_op);
    assign skip_cur = ignores_a(op_q);
`else
    assign skip_new = 1'b0;
    assign skip_cur = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = skip_new ? ST_LOADB : ST_LOADA;
            ST_LOADA: state_d = ST_LOADB;
            ST_LOADB: state_d = ST_EXEC;
            ST_EXEC:  state_d = wb_q ? ST_WB : ST_IDLE;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields are frozen at acceptance so source changes while busy are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            shift_q <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            shift_q <= cmd_shift;
            rn_q    <= cmd_rn;
            rm_q    <= cmd_rm;
            rd_q    <= cmd_rd;
            wb_q    <= cmd_wb;
        end
    end

    always_comb begin
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = ASEL_REG;
        bsel     = BSEL_REG;
        vsel     = 1'b0;
        shift    = SHIFT_NONE;
        ALUop    = ALU_ADD;
        done     = 1'b0;
        unique case (state_q)
            ST_LOADA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            ST_LOADB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                ALUop = op_q;
                shift = shift_q;
                loadc = 1'b1;
                loads = 1'b1;
                asel  = skip_cur ? ASEL_ZERO : ASEL_REG;
                done  = !wb_q;
            end
            ST_WB: begin
                vsel     = VSEL_C;
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    ctrl_op_counter #(
        .CNT_W(CNT_W)
    ) u_op_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (done),
        .count(op_count)
    );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Randomized bench: a register-file/ALU model driven by the DUT's enables is compared with
// a direct arithmetic reference, alongside per-cycle control-sequence checks.
module tb_datapath_ctrl;

    localparam int AW = 3;
    localparam int CW = 8;
`ifdef CTRL_SKIP_A_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_EX = 3, P_WB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rn = '0, cmd_rm = '0, cmd_rd = '0;
    logic [1:0]    cmd_shift = '0;
    logic          cmd_wb = 1'b0;
    logic [AW-1:0] readnum, writenum;
    logic          write, loada, loadb, loadc, loads, asel, bsel, vsel, done;
    logic [1:0]    shift, alu_op;
    logic [CW-1:0] op_count;

    datapath_ctrl #(
        .REG_ADDR_W(AW),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rn   (cmd_rn),
        .cmd_rm   (cmd_rm),
        .cmd_rd   (cmd_rd),
        .cmd_shift(cmd_shift),
        .cmd_wb   (cmd_wb),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (alu_op),
        .done     (done),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] shf_f(input logic [1:0] code, input logic [15:0] b);
        case (code)
            2'b00:   return b;
            2'b01:   return b << 1;
            2'b10:   return b >> 1;
            default: return {b[15], b[15:1]};
        endcase
    endfunction

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    // Datapath model obeying whatever enables the DUT produces.
    logic [15:0] dp_reg [8];
    logic [15:0] dp_a = '0, dp_b = '0, dp_c = '0;
    logic        dp_z = 1'b0;
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin : dp_model
        logic [15:0] res;
        res = alu_f(alu_op, asel ? 16'h0 : dp_a, shf_f(shift, dp_b));
        if (pl_en) dp_reg[pl_addr] <= pl_data;
        if (loada) dp_a <= dp_reg[readnum];
        if (loadb) dp_b <= dp_reg[readnum];
        if (loadc) dp_c <= res;
        if (loads) dp_z <= (res == 16'h0);
        if (write) dp_reg[writenum] <= vsel ? dp_c : 16'hxxxx;
    end

    // Reference: commands applied directly with plain arithmetic.
    logic [15:0]   ref_reg [8];
    logic          ref_z = 1'b0;
    logic [CW-1:0] cnt_model = '0;

    task automatic check_ctrl(input int ph, input logic [1:0] op, input logic [2:0] rn,
                              input logic [2:0] rm, input logic [2:0] rd, input logic [1:0] sh,
                              input logic wb);
        logic [9:0] got, exp;
        got = {write, loada, loadb, loadc, loads, asel, bsel, vsel, done, cmd_ready};
        exp = '0;
        case (ph)
            P_IDLE: exp[0] = 1'b1;
            P_A:    exp[8] = 1'b1;
            P_B:    exp[7] = 1'b1;
            P_EX: begin
                exp[6] = 1'b1;
                exp[5] = 1'b1;
                exp[4] = SKIP && (op == 2'b11);
                exp[1] = !wb;
            end
            default: begin
                exp[9] = 1'b1;
                exp[2] = 1'b1;
                exp[1] = 1'b1;
            end
        endcase
        check_eq($sformatf("ctrl_ph%0d", ph), 32'(got), 32'(exp));
        if (ph == P_IDLE || ph == P_A || ph == P_B)
            check_eq($sformatf("readnum_ph%0d", ph), 32'(readnum),
                     ph == P_A ? 32'(rn) : (ph == P_B ? 32'(rm) : 32'd0));
        if (ph == P_IDLE || ph == P_WB)
            check_eq($sformatf("writenum_ph%0d", ph), 32'(writenum),
                     ph == P_WB ? 32'(rd) : 32'd0);
        if (ph == P_IDLE || ph == P_EX) begin
            check_eq($sformatf("aluop_ph%0d", ph), 32'(alu_op), ph == P_EX ? 32'(op) : 32'd0);
            check_eq($sformatf("shift_ph%0d", ph), 32'(shift), ph == P_EX ? 32'(sh) : 32'd0);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_rn    = 3'($urandom_range(0, 7));
        cmd_rm    = 3'($urandom_range(0, 7));
        cmd_rd    = 3'($urandom_range(0, 7));
        cmd_shift = 2'($urandom_range(0, 3));
        cmd_wb    = 1'($urandom_range(0, 1));
    endtask

    // Call just after a falling edge with the DUT idle; returns just after the falling edge
    // that follows completion, so a following call is accepted back-to-back.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                           input logic [2:0] rd, input logic [1:0] sh, input logic wb,
                           input bit hold);
        int          ph[$];
        logic [15:0] res;
        if (!(SKIP && op == 2'b11)) ph.push_back(P_A);
        ph.push_back(P_B);
        ph.push_back(P_EX);
        if (wb) ph.push_back(P_WB);
        check_ctrl(P_IDLE, op, rn, rm, rd, sh, wb);
        check_eq("count_idle", 32'(op_count), 32'(cnt_model));
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_shift = sh; cmd_wb = wb;
        foreach (ph[i]) begin
            @(negedge clk);
            check_ctrl(ph[i], op, rn, rm, rd, sh, wb);
            cmd_valid = hold;
            scramble_cmd();
        end
        res = alu_f(op, ref_reg[rn], shf_f(sh, ref_reg[rm]));
        if (wb) ref_reg[rd] = res;
        ref_z = (res == 16'h0);
        cnt_model = cnt_model + 8'd1;
        @(negedge clk);
        check_eq("ready_after", 32'(cmd_ready), 32'd1);
        check_eq("count_after", 32'(op_count), 32'(cnt_model));
        check_eq("status", 32'(dp_z), 32'(ref_z));
        check_eq($sformatf("reg%0d", rd), 32'(dp_reg[rd]), 32'(ref_reg[rd]));
    endtask

    initial begin
        // Preload both register files while reset is held.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 3'(i);
            pl_data = (i == 6) ? 16'h8001 : 16'($urandom);
            ref_reg[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_ctrl", 32'({write, loada, loadb, loadc, loads, asel, vsel, done}), 32'd0);
        check_eq("rst_count", 32'(op_count), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rel_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b1, 1'b0);  // ADD with write-back
        check_eq("count_first", 32'(op_count), 32'd1);
        run_cmd(2'b01, 3'd4, 3'd5, 3'd6, 2'b00, 1'b0, 1'b0);  // SUB compare only
        run_cmd(2'b10, 3'd1, 3'd2, 3'd7, 2'b01, 1'b1, 1'b1);  // valid held high
        run_cmd(2'b00, 3'd3, 3'd4, 3'd5, 2'b10, 1'b1, 1'b0);
        run_cmd(2'b11, 3'd0, 3'd6, 3'd2, 2'b11, 1'b1, 1'b0);  // NOT B
        run_cmd(2'b11, 3'd7, 3'd1, 3'd0, 2'b01, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    (i != 39) && ($urandom_range(0, 1) == 1));
        end

        // Abort a write-back command in its execute cycle.
        cmd_valid = 1'b1;
        cmd_op = 2'b00; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_rd = 3'd4; cmd_shift = 2'b00;
        cmd_wb = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_ctrl(P_A, 2'b00, 3'd1, 3'd2, 3'd4, 2'b00, 1'b1);
        @(negedge clk);
        check_ctrl(P_B, 2'b00, 3'd1, 3'd2, 3'd4, 2'b00, 1'b1);
        @(negedge clk);
        check_ctrl(P_EX, 2'b00, 3'd1, 3'd2, 3'd4, 2'b00, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort_ctrl",
                 32'({write, loada, loadb, loadc, loads, asel, bsel, vsel, done, cmd_ready}),
                 32'd0);
        check_eq("abort_addr", 32'({readnum, writenum, alu_op, shift}), 32'd0);
        check_eq("abort_count", 32'(op_count), 32'd0);
        @(negedge clk);
        check_eq("abort_write", 32'(write), 32'd0);
        reset = 1'b0;
        cnt_model = '0;
        #1;
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check_eq("abort_reg4", 32'(dp_reg[4]), 32'(ref_reg[4]));

        for (int i = 0; i < 256; i++) begin
            if (i == 255) check_eq("count_255", 32'(op_count), 32'd255);
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        check_eq("count_wrap", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
